// File: rtl/freq_tracker_if.sv
// Signal bundle between the comparator front end / power stage and the frequency tracker.
interface freq_tracker_if;
   logic [31:0]        drive_frequency;
   logic               track_en;
   logic               v_zc;
   logic               i_zc;
   logic [31:0]        ftw;
   logic               drive_out;
   logic signed [15:0] phase_diff;
   logic               phase_valid;
   logic               locked;

   // Stimulus / control side
   modport master (
      output drive_frequency, track_en, v_zc, i_zc,
      input  ftw, drive_out, phase_diff, phase_valid, locked
   );

   // Tracker side
   modport slave (
      input  drive_frequency, track_en, v_zc, i_zc,
      output ftw, drive_out, phase_diff, phase_valid, locked
   );
endinterface

// File: rtl/freq_tracker.sv
// Resonant-frequency tracker: NCO drive generator, V/I zero-crossing phase measurement and
// closed-loop tuning-word correction with deadband, span clamp, lock detect and timeout.
module freq_tracker #(
   parameter logic [31:0] FTW_STEP   = 32'd43,
   parameter logic [31:0] FTW_SPAN   = 32'd429497,
   parameter logic [15:0] DEADBAND   = 16'd2,
   parameter int unsigned LOCK_COUNT = 8,
   parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
   input logic           clk_100M,
   input logic           rst,
   freq_tracker_if.slave bus
);

   localparam logic [7:0] LockMax = 8'(LOCK_COUNT);

   logic [2:0]         r_v_sync;
   logic [2:0]         r_i_sync;
   logic               r_v_edge;
   logic               r_i_edge;
   logic [31:0]        r_acc;
   logic [31:0]        r_ftw;
   logic [15:0]        r_per_cnt;
   logic [16:0]        r_period;
   logic               r_seen;
   logic               r_p_valid;
   logic               r_armed;
   logic [15:0]        r_vi_cnt;
   logic signed [15:0] r_phase_diff;
   logic               r_phase_valid;
   logic [7:0]         r_lock_cnt;

   logic               w_timeout;
   logic [15:0]        w_per_inc;
   logic               w_capture;
   logic               w_pv_now;
   logic [16:0]        w_t;
   logic [16:0]        w_half;
   logic signed [17:0] w_phase_wide;
   logic signed [15:0] w_phase_sat;
   logic [15:0]        w_abs;
   logic               w_in_band;
   logic [31:0]        w_lo;
   logic [31:0]        w_hi;
   logic [32:0]        w_cand;
   logic               w_neg;
   logic [31:0]        w_ftw_next;

   // Two-flop synchronizers plus registered rising-edge pulses for both comparators
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         r_v_sync <= '0;
         r_i_sync <= '0;
         r_v_edge <= 1'b0;
         r_i_edge <= 1'b0;
      end else begin
         r_v_sync <= {r_v_sync[1:0], bus.v_zc};
         r_i_sync <= {r_i_sync[1:0], bus.i_zc};
         r_v_edge <= r_v_sync[1] & ~r_v_sync[2];
         r_i_edge <= r_i_sync[1] & ~r_i_sync[2];
      end
   end

   // NCO phase accumulator
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         r_acc <= '0;
      end else begin
         r_acc <= r_acc + r_ftw;
      end
   end

   // Measurement control terms; a V edge in the timeout cycle restarts the period instead
   always_comb begin
      w_timeout = (r_per_cnt == TIMEOUT) && !r_v_edge;
      w_per_inc = (r_per_cnt == 16'hFFFF) ? r_per_cnt : r_per_cnt + 16'd1;
      w_capture = r_i_edge && (r_v_edge || r_armed);
      // A coincident V edge makes the period valid in the same cycle it is confirmed
      w_pv_now  = r_v_edge ? r_seen : r_p_valid;
      w_t       = r_v_edge ? 17'd0 : {1'b0, r_vi_cnt} + 17'd1;
   end

   // Period counter, period capture and period-valid qualification
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         r_per_cnt <= '0;
         r_period  <= '0;
         r_seen    <= 1'b0;
         r_p_valid <= 1'b0;
      end else if (r_v_edge) begin
         r_per_cnt <= '0;
         r_period  <= {1'b0, r_per_cnt} + 17'd1;
         r_seen    <= 1'b1;
         r_p_valid <= r_seen;
      end else begin
         r_per_cnt <= w_per_inc;
         if (w_timeout) begin
            r_seen    <= 1'b0;
            r_p_valid <= 1'b0;
         end
      end
   end

   // V-to-I lag counter: armed by a V edge, disarmed by the capturing I edge
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         r_armed  <= 1'b0;
         r_vi_cnt <= '0;
      end else if (w_timeout) begin
         r_armed <= 1'b0;
      end else if (r_v_edge && r_i_edge) begin
         r_armed  <= 1'b0;
         r_vi_cnt <= '0;
      end else if (r_v_edge) begin
         r_armed  <= 1'b1;
         r_vi_cnt <= '0;
      end else if (r_i_edge && r_armed) begin
         r_armed <= 1'b0;
      end else if (r_armed && (r_vi_cnt != 16'hFFFF)) begin
         r_vi_cnt <= r_vi_cnt + 16'd1;
      end
   end

   // Fold lag into (-P/2, P/2] and saturate to the 16-bit output range
   always_comb begin
      w_half = r_period >> 1;
      if (w_t <= w_half) begin
         w_phase_wide = $signed({1'b0, w_t});
      end else begin
         w_phase_wide = $signed({1'b0, w_t}) - $signed({1'b0, r_period});
      end
      if (w_phase_wide > 18'sd32767) begin
         w_phase_sat = 16'sd32767;
      end else if (w_phase_wide < -18'sd32767) begin
         w_phase_sat = -16'sd32767;
      end else begin
         w_phase_sat = w_phase_wide[15:0];
      end
   end

   // Phase result register and its one-cycle valid strobe
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         r_phase_diff  <= '0;
         r_phase_valid <= 1'b0;
      end else begin
         r_phase_valid <= w_capture && w_pv_now && !w_timeout;
         if (w_capture && w_pv_now && !w_timeout) begin
            r_phase_diff <= w_phase_sat;
         end
      end
   end

   // Corrected tuning word, clamped to the tracking window around nominal
   always_comb begin
      w_abs     = r_phase_diff[15] ? 16'(-r_phase_diff) : 16'(r_phase_diff);
      w_in_band = (w_abs <= DEADBAND);
      w_lo      = (bus.drive_frequency >= FTW_SPAN) ? bus.drive_frequency - FTW_SPAN : 32'd0;
      w_hi      = (bus.drive_frequency > ~FTW_SPAN) ? 32'hFFFF_FFFF
                                                    : bus.drive_frequency + FTW_SPAN;
      if (r_phase_diff > 0) begin
         // Current lags: lower the frequency; bit 32 flags a borrow below zero
         w_cand = {1'b0, r_ftw} - {1'b0, FTW_STEP};
         w_neg  = w_cand[32];
      end else begin
         w_cand = {1'b0, r_ftw} + {1'b0, FTW_STEP};
         w_neg  = 1'b0;
      end
      if (w_neg || (w_cand < {1'b0, w_lo})) begin
         w_ftw_next = w_lo;
      end else if (w_cand > {1'b0, w_hi}) begin
         w_ftw_next = w_hi;
      end else begin
         w_ftw_next = w_cand[31:0];
      end
   end

   // Tracking loop: open-loop follow, or per-measurement correction and lock counting
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         r_ftw      <= '0;
         r_lock_cnt <= '0;
      end else if (!bus.track_en) begin
         r_ftw      <= bus.drive_frequency;
         r_lock_cnt <= '0;
      end else if (w_timeout) begin
         r_lock_cnt <= '0;
      end else if (r_phase_valid) begin
         if (w_in_band) begin
            if (r_lock_cnt != LockMax) begin
               r_lock_cnt <= r_lock_cnt + 8'd1;
            end
         end else begin
            r_ftw      <= w_ftw_next;
            r_lock_cnt <= '0;
         end
      end
   end

   assign bus.ftw         = r_ftw;
   assign bus.drive_out   = r_acc[31];
   assign bus.phase_diff  = r_phase_diff;
   assign bus.phase_valid = r_phase_valid;
   assign bus.locked      = (r_lock_cnt == LockMax);

endmodule

// File: tb/tb_freq_tracker.sv
// Self-checking bench for freq_tracker: timestamp-based phase scoreboard plus tuning-word /
// lock model, with shortened span and timeout so clamp and timeout fit a short run.
module tb_freq_tracker;

   localparam logic [31:0] Step  = 32'd43;
   localparam logic [31:0] Span  = 32'd400;
   localparam logic [15:0] Db    = 16'd2;
   localparam int          LockN = 8;
   localparam logic [15:0] Tmo   = 16'd3000;
   localparam logic [31:0] Df    = 32'd42949673;
   localparam int          Per   = 200;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   freq_tracker_if u_bus ();

   freq_tracker #(
      .FTW_STEP   (Step),
      .FTW_SPAN   (Span),
      .DEADBAND   (Db),
      .LOCK_COUNT (LockN),
      .TIMEOUT    (Tmo)
   ) u_dut (
      .clk_100M (clk),
      .rst      (rst),
      .bus      (u_bus.slave)
   );

   int     n_checks = 0;
   int     n_fail   = 0;
   int     exp_q[$];
   longint exp_ftw  = 0;
   int     exp_lock = 0;
   bit     pend     = 1'b0;
   int     pv_count = 0;
   bit     clr_lock_req = 1'b0;

   // Stimulus-side measurement model (timestamps of driven edges)
   longint now_c  = 0;
   longint last_v = 0;
   longint prev_v = 0;
   int     nv     = 0;
   bit     m_armed = 1'b0;
   bit     lvl_v  = 1'b0;
   bit     lvl_i  = 1'b0;

   task automatic check_val(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic drive_cycle(input bit v, input bit i);
      bit     vr;
      bit     ir;
      longint t;
      longint p;
      @(posedge clk);
      #1;
      u_bus.v_zc = v;
      u_bus.i_zc = i;
      now_c++;
      vr = v && !lvl_v;
      ir = i && !lvl_i;
      if (vr) begin
         if (ir) begin
            if (nv >= 1) exp_q.push_back(0);
            m_armed = 1'b0;
         end else begin
            m_armed = 1'b1;
         end
         prev_v = last_v;
         last_v = now_c;
         nv++;
      end else if (ir && m_armed) begin
         m_armed = 1'b0;
         if (nv >= 2) begin
            t = now_c - last_v;
            p = last_v - prev_v;
            exp_q.push_back(int'((t <= p / 2) ? t : t - p));
         end
      end
      lvl_v = v;
      lvl_i = i;
   endtask

   task automatic run_seg(input int periods, input int delay);
      int k;
      for (int p = 0; p < periods; p++) begin
         for (int c = 0; c < Per; c++) begin
            k = (c + Per - delay) % Per;
            drive_cycle(c < Per / 2, k < Per / 2);
         end
      end
   endtask

   // Output monitor: pops expected phases and tracks the expected tuning word and lock state
   initial begin : monitor
      int     e;
      longint cand;
      longint lo;
      longint hi;
      longint dfl;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_ftw  = 0;
            exp_lock = 0;
            pend     = 1'b0;
         end else begin
            if (pend) begin
               check_val("ftw_after_pv", longint'(u_bus.ftw), exp_ftw);
               check_val("locked_after_pv", longint'(u_bus.locked),
                         (exp_lock == LockN) ? 1 : 0);
               pend = 1'b0;
            end
            if (clr_lock_req) begin
               exp_lock     = 0;
               clr_lock_req = 1'b0;
            end
            dfl = longint'(u_bus.drive_frequency);
            if (!u_bus.track_en) begin
               exp_ftw  = dfl;
               exp_lock = 0;
            end
            if (u_bus.phase_valid) begin
               pv_count++;
               if (exp_q.size() == 0) begin
                  check_val("pv_unexpected", longint'(exp_q.size()), 1);
               end else begin
                  e = exp_q.pop_front();
                  check_val("phase_diff", longint'(u_bus.phase_diff), longint'(e));
                  if (u_bus.track_en) begin
                     if (e > int'(Db) || e < -int'(Db)) begin
                        cand = (e > 0) ? exp_ftw - longint'(Step) : exp_ftw + longint'(Step);
                        lo = dfl - longint'(Span);
                        if (lo < 0) lo = 0;
                        hi = dfl + longint'(Span);
                        if (hi > 64'hFFFF_FFFF) hi = 64'hFFFF_FFFF;
                        if (cand < lo) cand = lo;
                        if (cand > hi) cand = hi;
                        exp_ftw  = cand;
                        exp_lock = 0;
                     end else if (exp_lock < LockN) begin
                        exp_lock++;
                     end
                     pend = 1'b1;
                  end
               end
            end
         end
      end
   end

   initial begin : stim
      int last_tog;
      bit prev_drv;
      int pv_before;
      rst                   = 1'b0;
      u_bus.track_en        = 1'b0;
      u_bus.drive_frequency = Df;
      u_bus.v_zc            = 1'b0;
      u_bus.i_zc            = 1'b0;

      // Inputs toggling under reset must leave every output at zero
      for (int n = 0; n < 8; n++) begin
         @(posedge clk);
         #1;
         u_bus.v_zc = n[0];
         u_bus.i_zc = n[1];
      end
      check_val("rst_ftw", longint'(u_bus.ftw), 0);
      check_val("rst_drive_out", longint'(u_bus.drive_out), 0);
      check_val("rst_phase_diff", longint'(u_bus.phase_diff), 0);
      check_val("rst_phase_valid", longint'(u_bus.phase_valid), 0);
      check_val("rst_locked", longint'(u_bus.locked), 0);
      u_bus.v_zc = 1'b0;
      u_bus.i_zc = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("open_loop_ftw", longint'(u_bus.ftw), longint'(Df));

      // 1 MHz drive: MSB toggles every 50 cycles
      last_tog = -1;
      prev_drv = u_bus.drive_out;
      for (int n = 0; n < 400; n++) begin
         drive_cycle(1'b0, 1'b0);
         if (u_bus.drive_out != prev_drv) begin
            if (last_tog >= 0) check_val("drive_half_period", longint'(n - last_tog), 50);
            last_tog = n;
         end
         prev_drv = u_bus.drive_out;
      end

      // Lag: current 20 ticks behind voltage
      u_bus.track_en = 1'b1;
      run_seg(6, 20);
      check_val("lag_phase", longint'(u_bus.phase_diff), 20);
      check_val("lag_ftw", longint'(u_bus.ftw), longint'(Df) - 5 * 43);

      // Lead: current 180 ticks behind on a 200 period, i.e. 20 ahead
      run_seg(6, 180);
      check_val("lead_phase", longint'(u_bus.phase_diff), -20);
      check_val("lead_ftw", longint'(u_bus.ftw), longint'(Df));

      // In-deadband measurements lock; one large error unlocks
      run_seg(10, 1);
      check_val("lock_set", longint'(u_bus.locked), 1);
      run_seg(2, 50);
      check_val("lock_lost", longint'(u_bus.locked), 0);
      check_val("lock_lost_ftw", longint'(u_bus.ftw), longint'(Df) - 2 * 43);
      run_seg(10, 1);
      check_val("relock", longint'(u_bus.locked), 1);

      // Voltage stops: timeout drops lock, no measurements appear, ftw holds
      pv_before = pv_count;
      for (int n = 0; n < int'(Tmo) + 500; n++) drive_cycle(1'b0, 1'b0);
      check_val("timeout_no_pv", longint'(pv_count - pv_before), 0);
      check_val("timeout_locked", longint'(u_bus.locked), 0);
      check_val("timeout_ftw_hold", longint'(u_bus.ftw), longint'(Df) - 2 * 43);
      nv           = 0;
      m_armed      = 1'b0;
      clr_lock_req = 1'b1;

      // Restart with coincident edges: zero phase once the period is re-qualified
      pv_before = pv_count;
      run_seg(3, 0);
      check_val("restart_pv_count", longint'(pv_count - pv_before), 2);
      check_val("restart_phase", longint'(u_bus.phase_diff), 0);

      // Sustained lag runs into the lower edge of the tracking window
      run_seg(15, 20);
      check_val("clamp_ftw", longint'(u_bus.ftw), longint'(Df) - longint'(Span));

      // Back to open loop: ftw follows a new nominal one cycle later
      u_bus.track_en        = 1'b0;
      u_bus.drive_frequency = Df + 32'd1000;
      drive_cycle(1'b0, 1'b0);
      check_val("follow_ftw", longint'(u_bus.ftw), longint'(Df) + 1000);
      check_val("follow_locked", longint'(u_bus.locked), 0);
      repeat (20) drive_cycle(1'b0, 1'b0);
      check_val("queue_drained", longint'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/freq_tracker.md
# freq_tracker

Resonant-frequency tracker for the ultrasonic drive path. It generates the transducer drive square wave from a 32-bit NCO. It measures the phase between the voltage and current zero-crossing comparator signals. It then steps the NCO tuning word so that the current comes into phase with the voltage. It sits between the comparator front end and the power stage, clocked from the 100 MHz system clock.

## Interface
Parameters:
- FTW_STEP, 32'd43, tuning-word step per correction (≈1 Hz at 100 MHz)
- FTW_SPAN, 32'd429497, max tracking deviation from nominal (≈±10 kHz)
- DEADBAND, 16'd2, |phase| ≤ DEADBAND ticks counts as in phase
- LOCK_COUNT, 8, consecutive in-deadband measurements needed to assert locked
- TIMEOUT, 16'hFFFF, cycles without a voltage edge before tracking is declared lost

Ports:
- clk_100M  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- drive_frequency  in  32  nominal NCO tuning word (f = FTW·100 MHz/2^32)
- track_en  in  1  1 = closed-loop tracking; 0 = ftw follows drive_frequency
- v_zc  in  1  voltage comparator, asynchronous to clk_100M
- i_zc  in  1  current comparator, asynchronous to clk_100M
- ftw  out  32  active tuning word
- drive_out  out  1  drive square wave = NCO accumulator MSB
- phase_diff  out  signed 16  last measured phase, in clock ticks
- phase_valid  out  1  one-cycle pulse when phase_diff updates
- locked  out  1  loop locked

## Operation
- v_zc and i_zc each pass through a 2-flop synchronizer followed by a rising-edge detector.
- NCO: acc <= acc + ftw every cycle. drive_out = acc[31].
- Period measurement: per_cnt is 16 bits and saturating, incremented every cycle. On a V edge, P <= per_cnt + 1 and per_cnt <= 0. The P_valid flag is set on the second V edge after reset or after a timeout.
- Lag measurement: a V edge clears vi_cnt and sets armed. vi_cnt increments while armed. An I edge while armed captures t = vi_cnt and clears armed. An I edge with armed = 0 is ignored. A V and I edge in the same cycle gives t = 0.
- Phase computation (only when P_valid): phase = t if t ≤ P/2 (P >> 1), else t − P. The result saturates to ±32767.
- Sign convention: positive phase means current lags voltage (inductive). The correction is ftw − FTW_STEP. Negative phase gives ftw + FTW_STEP.
- Loop:
  - If track_en = 0: ftw <= drive_frequency every cycle, the lock counter clears, and locked = 0.
  - If track_en = 1: on each phase_valid, apply the correction when |phase| > DEADBAND. The result is clamped to [drive_frequency − FTW_SPAN, drive_frequency + FTW_SPAN], computed with 33-bit arithmetic and floored at 0 and capped at 2^32−1.
  - If |phase| ≤ DEADBAND: ftw is unchanged and the lock counter increments, saturating at LOCK_COUNT.
  - locked = (lock counter == LOCK_COUNT). An out-of-deadband measurement clears the counter and locked.
- Timeout: when per_cnt reaches TIMEOUT, clear P_valid, armed, the lock counter and locked. ftw holds its value.

## Timing
- Reset values: ftw = 0, acc = 0, drive_out = 0, phase_diff = 0, phase_valid = 0, locked = 0. All counters, armed and P_valid are 0.
- Reset is asserted asynchronously and released synchronously through the flops. Reset mid-operation discards any measurement in progress.
- Edge-detect latency: 3 cycles from the input rising edge to the internal edge pulse. V and I have equal latency, so the measured lag is unaffected.
- phase_diff and phase_valid update 1 cycle after the I edge pulse.
- ftw updates 1 cycle after phase_valid. The NCO uses the new ftw from the following cycle.
- With track_en = 0, ftw follows drive_frequency with 1-cycle latency.
- A track_en 0→1 transition starts tracking from the current ftw. A measurement already armed completes normally.

## Test plan
- Reset: hold rst = 0, toggle the inputs → all outputs 0. Release reset with track_en = 0 and drive_frequency = 42949673 → ftw = 42949673 one cycle later, and drive_out toggles every 50 cycles (1 MHz).
- Lag: v_zc period 1000 cycles, i_zc delayed 100 cycles, track_en = 1 → phase_diff = 100 with phase_valid once per period, and ftw decreases by 43 per measurement.
- Lead: i_zc delayed 900 cycles on a 1000-cycle period → phase_diff = −100, and ftw increases by 43 per measurement.
- Lock: i_zc delayed 1 cycle → ftw constant, and locked rises on the 8th phase_valid. Then change the delay to 50 → locked falls on the next phase_valid.
- Clamp: sustained 100-cycle lag for more than 10^4 periods → ftw stops at drive_frequency − 429497.
- Timeout and simultaneous edges: stop v_zc → after 65535 cycles locked = 0 and no phase_valid pulses. Restart with v_zc = i_zc (in phase) → after 2 V edges phase_diff = 0.
